// File: rtl/a5_pkg.sv
// Shared types and constants for the A5/1 burst keyer.
package a5_pkg;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;
    localparam int LOAD_BITS  = KEY_BITS + FRAME_BITS;
    localparam int KS_TOTAL   = 228;

    typedef enum logic [2:0] {
        IDLE,
        GENRST,
        ARM,
        LOAD,
        WAIT_DONE,
        COLLECT,
        DONE
    } state_t;

endpackage

// File: rtl/a5_load_shifter.sv
// Parallel-load / serial-out register that streams key then frame bits, LSB first.
module a5_load_shifter
    import a5_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 load,
    input  logic [LOAD_BITS-1:0] load_data,
    input  logic                 shift,
    output logic                 serial_bit,
    output logic                 done
);

    logic [LOAD_BITS-1:0] sreg;
    logic [6:0]           bit_cnt;

    assign serial_bit = sreg[0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else if (load) begin
            sreg    <= load_data;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else if (shift && !done) begin
            sreg    <= {1'b0, sreg[LOAD_BITS-1:1]};
            bit_cnt <= bit_cnt + 7'd1;
            // done rises together with the shift that hands out the last bit
            done    <= (bit_cnt == 7'(LOAD_BITS - 1));
        end
    end

endmodule

// File: rtl/a5_burst_keyer.sv
// Frame controller for one A5/1 generator: reset, serial key/frame load, 228-bit capture.
// Optional A5_BURST_XOR_EN adds Data_dl/Data_ul inputs and registered Out_dl/Out_ul.
module a5_burst_keyer
    import a5_pkg::*;
#(
    parameter int KS_LEN  = 114,
    parameter int TIMEOUT = 255
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [KEY_BITS-1:0]   Key,
    input  logic [FRAME_BITS-1:0] Frame,
    output logic                  Busy,
    output logic                  Ks_valid,
    output logic                  Error,
    output logic [KS_LEN-1:0]     Ks_dl,
    output logic [KS_LEN-1:0]     Ks_ul,
    output logic                  Gen_reset_n,
    output logic                  Startloading,
    output logic                  Keybit,
    input  logic                  Bitout,
    input  logic                  Doneloading
`ifdef A5_BURST_XOR_EN
    ,
    input  logic [KS_LEN-1:0]     Data_dl,
    input  logic [KS_LEN-1:0]     Data_ul,
    output logic [KS_LEN-1:0]     Out_dl,
    output logic [KS_LEN-1:0]     Out_ul
`endif
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0] DL_BITS     = 8'(KS_LEN);
    localparam logic [7:0] LAST_BIT    = 8'(2 * KS_LEN - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       start_ok;
    logic       sh_shift;
    logic       sh_bit;
    logic       sh_done;
    logic       last_capture;

    assign start_ok     = Start && ((state == IDLE) || (state == DONE));
    assign sh_shift     = (state == ARM) || ((state == LOAD) && !sh_done);
    assign last_capture = (state == COLLECT) && (cnt == LAST_BIT);

    a5_load_shifter u_load_shifter (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .load       (start_ok),
        .load_data  ({Frame, Key}),
        .shift      (sh_shift),
        .serial_bit (sh_bit),
        .done       (sh_done)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            Busy         <= 1'b0;
            Ks_valid     <= 1'b0;
            Error        <= 1'b0;
            Ks_dl        <= '0;
            Ks_ul        <= '0;
            Gen_reset_n  <= 1'b0;
            Startloading <= 1'b0;
            Keybit       <= 1'b0;
        end else begin
            Gen_reset_n  <= 1'b1;
            Startloading <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // generator never leaves RUNNING by itself, so each frame re-resets it
                    if (Start) begin
                        state       <= GENRST;
                        Gen_reset_n <= 1'b0;
                        Busy        <= 1'b1;
                        Ks_valid    <= 1'b0;
                        Error       <= 1'b0;
                        cnt         <= '0;
                    end
                end
                GENRST: begin
                    Startloading <= 1'b1;
                    state        <= ARM;
                end
                ARM: begin
                    Keybit <= sh_bit;
                    state  <= LOAD;
                end
                LOAD: begin
                    if (sh_done) begin
                        Keybit <= 1'b0;
                        state  <= WAIT_DONE;
                    end else begin
                        Keybit <= sh_bit;
                    end
                end
                WAIT_DONE: begin
                    if (Doneloading) begin
                        Ks_dl <= {Ks_dl[KS_LEN-2:0], Bitout};
                        cnt   <= 8'd1;
                        state <= COLLECT;
                    end else if (cnt == TIMEOUT_CNT) begin
                        Error <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                COLLECT: begin
                    if (cnt < DL_BITS) begin
                        Ks_dl <= {Ks_dl[KS_LEN-2:0], Bitout};
                    end else begin
                        Ks_ul <= {Ks_ul[KS_LEN-2:0], Bitout};
                    end
                    cnt <= cnt + 8'd1;
                    if (last_capture) begin
                        Ks_valid <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef A5_BURST_XOR_EN
    logic [KS_LEN-1:0] data_dl_q;
    logic [KS_LEN-1:0] data_ul_q;

    // Out_ul folds in the bit captured on the same edge Ks_valid rises
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_dl_q <= '0;
            data_ul_q <= '0;
            Out_dl    <= '0;
            Out_ul    <= '0;
        end else begin
            if (start_ok) begin
                data_dl_q <= Data_dl;
                data_ul_q <= Data_ul;
            end
            if (last_capture) begin
                Out_dl <= Ks_dl ^ data_dl_q;
                Out_ul <= {Ks_ul[KS_LEN-2:0], Bitout} ^ data_ul_q;
            end
        end
    end
`endif

endmodule

// File: doc/a5_burst_keyer.md
Name: a5_burst_keyer

Overview:
Controller on the far side of the A5/1 keystream generator's serial load interface.
- Per frame: pulses the generator's reset, issues Startloading, and shifts the 64-bit key and the 22-bit frame number in one bit per clock.
- Waits for Doneloading, then captures 228 keystream bits as a 114-bit downlink block and a 114-bit uplink block for the burst (de)cipher datapath.
- Sits between the frame scheduler (Key/Frame/Start) and one generator instance.

Parameters:
- KS_LEN, 114, bits per direction block.
- TIMEOUT, 255, max cycles in WAIT_DONE before Error; 8-bit counter, range 1..255.

Ports:
- Clk  in  1  clock
- Reset_n  in  1  asynchronous active-low reset
- Start  in  1  request new frame; sampled only in IDLE
- Key  in  64  session key; Key[0] loaded first, byte i = Key[8i+7:8i], LSB first
- Frame  in  22  frame number; Frame[0] loaded first
- Busy  out  1  high in every state except IDLE and DONE
- Ks_valid  out  1  level; Ks_dl/Ks_ul valid
- Error  out  1  sticky; Doneloading timeout
- Ks_dl  out  KS_LEN  keystream bits 0..113; first bit at [113]
- Ks_ul  out  KS_LEN  keystream bits 114..227; bit 114 at [113]
- Gen_reset_n  out  1  generator reset, registered
- Startloading  out  1  to generator, registered
- Keybit  out  1  to generator, registered
- Bitout  in  1  generator keystream
- Doneloading  in  1  generator ready

Behaviour:
- Clock and reset: one clock (Clk); Reset_n is asynchronous and active-low.
- Reset values: Busy=0, Ks_valid=0, Error=0, Ks_dl=Ks_ul=0, Gen_reset_n=0, Startloading=0, Keybit=0, state IDLE, counter 0.
  - Gen_reset_n stays low while Reset_n is low and goes high on the first Clk edge after release.
- Start acceptance: Key and Frame are latched at the Start edge (t0); later input changes are ignored.
- IDLE: on Start, latch Key/Frame, clear Ks_valid, Error and counter, then go to GENRST.
- GENRST: Gen_reset_n=0 for exactly one cycle (t0..t1), then go to ARM.
  - The generator never leaves RUNNING on its own, so every frame re-resets it.
- ARM: Startloading=1 for exactly one cycle (t1..t2), Keybit=0.
- LOAD: 86 cycles.
  - Keybit holds stream bit n during cycle t(2+n)..t(3+n), n=0..85.
  - Bits 0..63 come from the latched Key, bits 64..85 from the latched Frame.
  - After n=85, go to WAIT_DONE.
- WAIT_DONE: Keybit=0. Counter increments each cycle.
  - Doneloading=1: capture Bitout as bit 0 on that edge, go to COLLECT.
  - Counter reaches TIMEOUT: set Error, go to DONE with Ks_valid=0.
- COLLECT: capture Bitout every edge.
  - Bits 1..113 shift into Ks_dl from LSB (shift left).
  - Bits 114..227 shift into Ks_ul the same way.
  - On capture of bit 227, set Ks_valid and go to DONE.
  - With a conforming generator, bit 0 is captured at t191 and Ks_valid rises at t418.
- DONE: outputs held.
  - Start restarts exactly as from IDLE. Ks_valid drops on the restart edge; Ks_dl/Ks_ul hold until overwritten by shifting.
- Start while Busy: ignored, never queued.
- Doneloading dropping during COLLECT: capture continues. It is not a protocol error.
- Reset mid-operation: all state returns to reset values, and Gen_reset_n low also resets the generator.

Optional Feature:
- Macro: A5_BURST_XOR_EN.
- Defined:
  - Adds inputs Data_dl[KS_LEN-1:0] and Data_ul[KS_LEN-1:0], latched at the Start edge.
  - Adds outputs Out_dl and Out_ul, each KS_LEN wide: Out_dl = Ks_dl ^ latched Data_dl, Out_ul = Ks_ul ^ latched Data_ul. Both are registered and update on the edge Ks_valid rises.
  - Out_dl and Out_ul reset to 0.
- Undefined: these ports and registers do not exist. Ks_dl/Ks_ul behaviour is unchanged.

Decomposition:
- Package a5_pkg:
  - state enum: IDLE, GENRST, ARM, LOAD, WAIT_DONE, COLLECT, DONE
  - constants: KEY_BITS=64, FRAME_BITS=22, LOAD_BITS=86, KS_TOTAL=228
- Sub-module a5_load_shifter: 86-bit parallel-load/serial-out register with a bit counter and a done flag. Used by LOAD.

Test Plan:
- Key=64'hEFCDAB8967452312, Frame=22'h134, Start one cycle, generator attached -> Ks_dl[113:82]=32'h534EAA58, Ks_valid rises 418 cycles after the Start edge, Error=0.
- Same key, observe the generator pins -> Gen_reset_n low exactly 1 cycle, Startloading high exactly 1 cycle, Keybit sequence = 0,1,0,0,1,0,0,0 (0x12 LSB-first), ..., then Frame bits 0,0,1,0,1,1,0,0,1,0 (0x134 LSB-first).
- Doneloading tied 0, TIMEOUT=10 -> Error=1 eleven cycles after the last key bit, state DONE, Ks_valid=0, Busy=0.
- Start pulsed at cycle 50 of LOAD -> ignored, Keybit sequence unchanged; second Start in DONE -> Ks_valid drops next cycle, full reload, same keystream result.
- Reset_n asserted during COLLECT -> all outputs at reset values immediately; after release, a new Start yields the correct 0x534EAA58 prefix.
- A5_BURST_XOR_EN defined, Data_dl=all-ones -> Out_dl[113:82]=32'hACB155A7.
